// File: rtl/aes_256_para_ctrl.sv
// aes_256_para_ctrl: round sequencer and batch front end for the 16-lane
// parallel AES-256 round datapath.
//
// A batch of LANES blocks is accepted over in_valid/in_ready and held in a
// per-lane state register. The controller then runs NR rounds, one round at a
// time. For each round it presents dp_round, dp_round_key and dp_input_text
// to the datapath and holds them stable. After PE_LAT cycles it captures
// dp_output_text back into the state register. The finished batch is offered
// on out_valid/out_ready. Round keys live in an NR-entry store that can only
// be written while the controller is idle.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   key_we/addr/data    round-key store write port (IDLE only, addr < NR)
//   in_valid/ready/data input batch handshake
//   out_valid/ready/data result batch handshake
//   busy                high in RUN or DONE
//   dp_input_text       state register driven to the datapath
//   dp_round            current round index (0 outside RUN)
//   dp_round_key        key[dp_round] (0 outside RUN)
//   dp_output_text      datapath result, valid PE_LAT cycles after inputs

// One lane's slice of the batch state register.
module aes_256_para_lane #(
  parameter int BS = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_in,
  input  logic          load_dp,
  input  logic [BS-1:0] in_blk,
  input  logic [BS-1:0] dp_blk,
  output logic [BS-1:0] state_q
);
  logic [BS-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load_in)      state_d = in_blk;
    else if (load_dp) state_d = dp_blk;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= '0;
    else        state_q <= state_d;
  end
endmodule

module aes_256_para_ctrl #(
  parameter int block_size = 128,
  parameter int LANES      = 16,
  parameter int NR         = 15,
  parameter int PE_LAT     = 2,
  localparam int W         = block_size * LANES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_we,
  input  logic [3:0]            key_addr,
  input  logic [block_size-1:0] key_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
  output logic                  busy,
  output logic [W-1:0]          dp_input_text,
  output logic [3:0]            dp_round,
  output logic [block_size-1:0] dp_round_key,
  input  logic [W-1:0]          dp_output_text
);
  localparam int CW = (PE_LAT < 1) ? 1 : $clog2(PE_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                       fsm_q, fsm_d;
  logic [3:0]                   rnd_q, rnd_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [block_size-1:0]        key_q [NR];
  logic [block_size-1:0]        key_d [NR];
  logic [LANES-1:0][block_size-1:0] state_reg;

  logic accept, round_end, last_round;

  assign accept     = (fsm_q == IDLE) && in_valid;
  // The datapath output is valid on the last cycle of the round.
  assign round_end  = (fsm_q == RUN) && (cnt_q == CW'(PE_LAT));
  assign last_round = (rnd_q == 4'(NR - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      rnd_q <= '0;
      cnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      cnt_q <= cnt_d;
    end
  end

  // Next-state and round/cycle counters
  always_comb begin
    fsm_d = fsm_q;
    rnd_d = rnd_q;
    cnt_d = cnt_q;
    case (fsm_q)
      IDLE: if (in_valid) begin
        fsm_d = RUN;
        rnd_d = '0;
        cnt_d = '0;
      end
      RUN: begin
        if (round_end) begin
          cnt_d = '0;
          if (last_round) fsm_d = DONE;
          else            rnd_d = rnd_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    dp_round     = '0;
    dp_round_key = '0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      RUN: begin
        dp_round     = rnd_q;
        dp_round_key = key_q[rnd_q];
      end
      DONE:    out_valid = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Key store: not reset, so keys survive a controller reset. Locked
  // outside IDLE, which keeps the key set constant for a whole batch.
  always_comb begin
    key_d = key_q;
    if (key_we && (fsm_q == IDLE) && (key_addr < 4'(NR)))
      key_d[key_addr] = key_data;
  end

  always_ff @(posedge clk) begin
    key_q <= key_d;
  end

  // Batch state register, one instance per lane
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_256_para_lane #(.BS(block_size)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_in (accept),
      .load_dp (round_end),
      .in_blk  (in_data[(i+1)*block_size-1 -: block_size]),
      .dp_blk  (dp_output_text[(i+1)*block_size-1 -: block_size]),
      .state_q (state_reg[i])
    );
  end

  assign dp_input_text = state_reg;
  assign out_data      = state_reg;
endmodule

// File: doc/aes_256_para_ctrl.md
Name: aes_256_para_ctrl

Overview:
- Round sequencer and batch front end for the 16-lane parallel AES-256 round datapath.
- Accepts a batch of 16 x 128-bit blocks over a valid/ready handshake and holds it in a state register.
- Drives the datapath's round index, round key and input text, one round at a time, for NR rounds, capturing the datapath output after each round.
- Returns the finished 2048-bit batch over a valid/ready handshake. Round keys are held in an internal 15-entry key store, loaded through a write port.

Parameters:
- block_size, 128, width of one AES block.
- LANES, 16, blocks per batch; batch width W = block_size*LANES.
- NR, 15, number of round operations per batch (rounds 0..NR-1).
- PE_LAT, 2, cycles from dp_round/dp_round_key/dp_input_text being stable to dp_output_text being valid. Must be >=1.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- key_we  in  1  round-key store write enable.
- key_addr  in  4  round-key index 0..NR-1.
- key_data  in  block_size  round key value.
- in_valid  in  1  input batch valid.
- in_ready  out  1  controller can accept a batch.
- in_data  in  W  input batch; lane i at bits [(i+1)*block_size-1 -: block_size].
- out_valid  out  1  result batch valid.
- out_ready  in  1  sink accepts result.
- out_data  out  W  result batch, same lane packing as in_data.
- busy  out  1  high in RUN or DONE.
- dp_input_text  out  W  to datapath input_text.
- dp_round  out  4  to datapath round.
- dp_round_key  out  block_size  to datapath round_key.
- dp_output_text  in  W  from datapath output_text.

Behaviour:
- Synchronous, active-low reset. It clears the FSM to IDLE, rnd=0, cnt=0 and state_reg=0. It leaves the key store untouched; keys survive reset. Reset values: in_ready=1 from the first cycle after reset, out_valid=0, busy=0, dp_round=0, dp_round_key=0.
- Reset asserted mid-operation abandons the batch; no out_valid for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, dp_round=0, dp_round_key=0.
  - On in_valid&in_ready: state_reg<=in_data, rnd<=0, cnt<=0, go to RUN.
- RUN:
  - in_ready=0, dp_round=rnd, dp_round_key=key[rnd]. All are registered/stable for the whole round.
  - cnt increments each cycle.
  - When cnt==PE_LAT: state_reg<=dp_output_text and cnt<=0.
    - If rnd==NR-1, go to DONE.
    - Otherwise rnd<=rnd+1.
- Round timing:
  - Each round takes PE_LAT+1 cycles.
  - out_valid first rises NR*(PE_LAT+1) cycles after the acceptance edge. With defaults that is 45.
- DONE:
  - out_valid=1, out_data=state_reg; both are held stable until out_ready.
  - On out_valid&out_ready, go to IDLE. in_ready rises the following cycle, so there is no same-cycle in/out overlap.
- dp_input_text=state_reg at all times.
- Key store:
  - A write with key_we=1, key_addr<NR and FSM==IDLE updates key[key_addr] at the edge.
  - Writes while busy are ignored (keys locked during a batch).
  - Writes with key_addr>=NR are ignored.
  - A key written in the same cycle as an accepted batch is used by that batch.
- in_valid while not ready: no effect. The source must hold its data.
- out_ready while out_valid=0: no effect.
- Simultaneous rst_n=0 with any handshake: reset wins.

Test Plan:
- Bench datapath model: a PE_LAT-cycle pipeline computing output = input_text XOR {16{round_key}}.
- Test 1, single batch: load key[r]=128'h(r+1) replicated pattern for r=0..14; batch lane i=128'hi; out_ready=1.
  - out_valid rises exactly 45 cycles after acceptance.
  - Each lane = i XOR (XOR of all 15 keys).
  - dp_round steps 0..14, each value held 3 cycles.
- Test 2, backpressure: as test 1 with out_ready=0 for 20 cycles after out_valid.
  - out_data stable, in_ready=0 throughout.
  - After out_ready=1, out_valid drops next cycle; in_ready=1 next cycle.
- Test 3, key lock: during RUN write key[0]=all-ones; also write key_addr=15 while IDLE.
  - Result is identical to test 1.
  - A second batch also matches test 1 (neither write took effect).
- Test 4, mid-op reset: pulse rst_n=0 for 1 cycle at round 7.
  - Next cycle: in_ready=1, out_valid=0, busy=0.
  - A new batch then completes correctly using the pre-reset keys.
- Test 5, back-to-back batches with in_valid held high and out_ready=1.
  - Second acceptance occurs 1 cycle after the first output handshake.
  - Both results correct.
- Test 6, PE_LAT=1 parameterisation: out_valid latency is 30 cycles, results correct.
